// File: rtl/axi_read_master.sv
// AXI4 read master: accepts one burst command, issues a single AR, and forwards
// R beats through a one-entry output register, with the burst length set by its own beat counter.
module axi_read_master #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] araddr_q;
  logic [7:0]               arlen_q;
  logic [7:0]               beat_cnt_q;
  logic [7:0]               beat_cnt_d;
  logic [DATA_WIDTH-1:0]    out_data_q;
  logic                     out_last_q;
  logic                     out_valid_q;
  logic                     done_q;
  logic                     err_q;
  logic                     err_d;
  logic                     cmd_fire;
  logic                     beat_fire;
  logic                     final_beat;

  // cmd_ready is gated by areset so it reads 0 while reset is held, even though state is IDLE.
  assign cmd_ready  = (state_q == IDLE) && !areset;
  assign arvalid    = (state_q == ADDR);
  assign rready     = (state_q == DATA) && (!out_valid_q || out_ready);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign beat_fire  = rvalid && rready;
  assign final_beat = (beat_cnt_q == arlen_q);
  assign beat_cnt_d = beat_cnt_q + 8'd1;
  assign err_d      = err_q || (rresp != 2'b00) || (rlast != final_beat);

  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = BEAT_SIZE;
  assign arburst   = 2'b01;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A load in the same cycle as a drain overrides the clear above.
      if (beat_fire) begin
        out_data_q  <= rdata;
        out_valid_q <= 1'b1;
        out_last_q  <= final_beat;
        beat_cnt_q  <= beat_cnt_d;
        err_q       <= err_d;
      end
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            araddr_q   <= cmd_addr;
            arlen_q    <= cmd_len;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (beat_fire && final_beat) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Randomized-data directed bench for axi_read_master, checked against a beat-stream
// model (captured/drained counts, error flag from the rules) kept in the bench.
module tb_axi_read_master;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          aclk;
  logic          areset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          err;

  int total;
  int bad;

  axi_read_master #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    checkOutput({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    checkOutput({tag, "_rready"}, 64'(rready), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_araddr"}, 64'(araddr), 64'd0);
    checkOutput({tag, "_arlen"}, 64'(arlen), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  // readyMode: 0 out_ready always 1, 1 toggles 1/0, 2 random out_ready and rvalid gaps.
  // abortAt >= 0 pulses areset while that beat index is being presented.
  task automatic applyStimulus(input logic [AW-1:0] addr, input int len, input int arDelay,
                               input int rlastIdx, input int errIdx, input int readyMode,
                               input int abortAt);
    int n;
    int rIdx;
    int outIdx;
    int cycles;
    bit errModel;
    bit finalCaptured;
    bit doneExpect;
    bit doneChecked;
    bit expRready;
    bit drain;
    bit capture;
    logic [DW-1:0] dataQ[$];
    n = len + 1;
    rIdx = 0;
    outIdx = 0;
    cycles = 0;
    errModel = 1'b0;
    finalCaptured = 1'b0;
    doneExpect = 1'b0;
    doneChecked = 1'b0;
    for (int i = 0; i < n; i++) dataQ.push_back($urandom);

    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_addr = addr;
    cmd_len = 8'(len);
    #1;
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_addr = AW'($urandom);
    cmd_len = 8'($urandom);

    for (int c = 0; c <= arDelay; c++) begin
      arready = (c == arDelay);
      #1;
      checkOutput("arvalid", 64'(arvalid), 64'd1);
      checkOutput("araddr", 64'(araddr), 64'(addr));
      checkOutput("arlen", 64'(arlen), 64'(len));
      checkOutput("arsize", 64'(arsize), 64'd2);
      checkOutput("arburst", 64'(arburst), 64'd1);
      checkOutput("cmd_ready_addr", 64'(cmd_ready), 64'd0);
      checkOutput("err_cleared", 64'(err), 64'd0);
      @(negedge aclk);
    end
    arready = 1'b0;

    forever begin
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = (cycles % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rvalid = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata = (rIdx < n) ? dataQ[rIdx] : $urandom;
      rlast = (rIdx == rlastIdx);
      rresp = (rIdx == errIdx) ? 2'b10 : 2'b00;

      if (abortAt >= 0 && rIdx == abortAt) begin
        areset = 1'b1;
        #1;
        checkAllZero("rst_mid");
        @(negedge aclk);
        #1;
        checkAllZero("rst_held");
        @(negedge aclk);
        areset = 1'b0;
        rvalid = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
        checkOutput("out_valid_after_rst", 64'(out_valid), 64'd0);
        return;
      end

      #1;
      expRready = !finalCaptured && (!(rIdx > outIdx) || out_ready);
      checkOutput("rready", 64'(rready), 64'(expRready));
      checkOutput("out_valid", 64'(out_valid), 64'(rIdx > outIdx));
      checkOutput("done", 64'(done), 64'(doneExpect));
      checkOutput("err", 64'(err), 64'(errModel));
      checkOutput("arvalid_data", 64'(arvalid), 64'd0);
      checkOutput("cmd_ready_data", 64'(cmd_ready), 64'(finalCaptured));
      if (rIdx > outIdx) begin
        checkOutput("out_data", 64'(out_data), 64'(dataQ[outIdx]));
        checkOutput("out_last", 64'(out_last), 64'(outIdx == n - 1));
      end
      if (doneExpect) doneChecked = 1'b1;
      if (finalCaptured && outIdx == n && doneChecked && !doneExpect) break;

      drain = (rIdx > outIdx) && out_ready;
      capture = rvalid && expRready;
      doneExpect = capture && (rIdx == n - 1);
      if (drain) outIdx++;
      if (capture) begin
        if (rresp != 2'b00 || rlast != (rIdx == n - 1)) errModel = 1'b1;
        rIdx++;
        if (rIdx == n) finalCaptured = 1'b1;
      end
      cycles++;
      if (cycles > 3000) begin
        checkOutput("burst_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge aclk);
    end

    rvalid = 1'b0;
    @(negedge aclk);
    #1;
    checkOutput("err_held_after_done", 64'(err), 64'(errModel));
    checkOutput("done_low_after", 64'(done), 64'd0);
    checkOutput("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    areset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    arready = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    rlast = 1'b0;
    rvalid = 1'b0;
    out_ready = 1'b0;

    $display("[TB] reset check");
    repeat (2) @(negedge aclk);
    #1;
    checkAllZero("rst_init");
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    checkOutput("cmd_ready_first_clock", 64'(cmd_ready), 64'd1);

    $display("[TB] basic 6-beat burst");
    applyStimulus(8'h10, 5, 0, 5, -1, 0, -1);
    $display("[TB] 6-beat burst with toggling out_ready");
    applyStimulus(8'h10, 5, 0, 5, -1, 1, -1);
    $display("[TB] single beat with arready stall");
    applyStimulus(8'h3c, 0, 3, 0, -1, 0, -1);
    $display("[TB] early rlast and slave error");
    applyStimulus(8'h44, 3, 1, 1, 2, 0, -1);
    $display("[TB] next command clears err");
    applyStimulus(8'h48, 2, 0, 2, -1, 1, -1);
    $display("[TB] missing rlast on final beat");
    applyStimulus(8'h50, 2, 0, -1, -1, 0, -1);
    $display("[TB] reset mid-burst");
    applyStimulus(8'h60, 7, 0, 7, -1, 0, 2);
    $display("[TB] fresh command after reset");
    applyStimulus(8'h64, 7, 2, 7, -1, 2, -1);
    $display("[TB] 256-beat burst");
    applyStimulus(8'h80, 255, 0, 255, -1, 2, -1);
    $display("[TB] random bursts");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(AW'($urandom), $urandom_range(0, 20), $urandom_range(0, 3),
                    -2, -1, $urandom_range(0, 2), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 8, the AXI address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the AXI data width (power of two, 8..128).
REQ-003 Ports, in this order (name, direction, width, meaning):
  aclk        in   1              single clock; all logic on rising edge
  areset      in   1              asynchronous, active-high reset
  cmd_valid   in   1              burst request valid
  cmd_ready   out  1              burst request accepted when high with cmd_valid
  cmd_addr    in   ADDRESS_WIDTH  burst start address
  cmd_len     in   8              beats minus one (AXI arlen encoding)
  araddr      out  ADDRESS_WIDTH  AR address
  arlen       out  8              AR burst length
  arsize      out  3              AR beat size
  arburst     out  2              AR burst type
  arvalid     out  1              AR valid
  arready     in   1              AR ready
  rdata       in   DATA_WIDTH     R data
  rresp       in   2              R response
  rlast       in   1              R last
  rvalid      in   1              R valid
  rready      out  1              R ready
  out_data    out  DATA_WIDTH     forwarded beat data
  out_last    out  1              forwarded beat is final beat of burst
  out_valid   out  1              forwarded beat valid
  out_ready   in   1              downstream ready
  done        out  1              one-cycle pulse: final beat captured
  err         out  1              sticky error for current or last burst

Function
REQ-004 State machine SHALL have states IDLE, ADDR, DATA; cmd_ready SHALL be 1 only in IDLE.
REQ-005 IDLE: on cmd_valid && cmd_ready, the module SHALL register cmd_addr/cmd_len, clear err and beat counter, and enter ADDR next cycle.
REQ-006 ADDR: arvalid SHALL be 1 with araddr/arlen equal to the registered values, stable until arready; on arvalid && arready the module SHALL enter DATA next cycle with arvalid 0.
REQ-007 arsize SHALL be constant log2(DATA_WIDTH/8) (2 for 32-bit) and arburst SHALL be constant 2'b01 (INCR).
REQ-008 A single output register SHALL hold one beat; rready SHALL be 1 only in DATA and only when out_valid is 0 or out_ready is 1 (combinational, zero-bubble).
REQ-009 On rvalid && rready the module SHALL load out_data=rdata, out_valid=1, out_last=(beat counter == arlen), and increment the 8-bit beat counter.
REQ-010 out_valid SHALL clear on out_valid && out_ready unless a new beat loads the same cycle; simultaneous drain and load SHALL keep out_valid 1 with the new beat.
REQ-011 Burst length SHALL be set by the counter: the beat with counter == arlen ends the burst regardless of rlast; no further rready for that burst.
REQ-012 err SHALL set when a captured beat has rresp != 2'b00, rlast=1 with counter != arlen, or rlast=0 with counter == arlen.
REQ-013 On capture of the final beat the module SHALL pulse done for one cycle and return to IDLE next cycle; the output register MAY still hold that beat while a new command is accepted.
REQ-014 arlen=0 SHALL yield exactly one beat with out_last=1; arlen=255 SHALL yield 256 beats with no counter overflow before out_last.
REQ-015 err SHALL remain set after done until the next command is accepted.

Reset
REQ-016 While areset is high, state SHALL be IDLE and cmd_ready, arvalid, rready, out_valid, out_last, done, err SHALL be 0; araddr, arlen, out_data SHALL be 0.
REQ-017 cmd_ready SHALL go to 1 in the first clock after areset deasserts.
REQ-018 areset asserted mid-burst SHALL immediately drop arvalid/rready/out_valid and discard the in-flight burst.

Verification
REQ-019 cmd_addr=0x10, cmd_len=5, arready=1, rvalid=1 each cycle with rlast on beat 6, rresp=0, out_ready=1 -> AR 0x10/len 5/size 2/burst 01, six out beats, out_last on beat 6 only, done pulse once, err=0.
REQ-020 Same burst with out_ready toggling 1,0 -> rready follows REQ-008, no beat lost or duplicated, data order preserved.
REQ-021 cmd_len=0, arready held 0 for 3 cycles -> arvalid and araddr stable 3 cycles, then one beat with out_last=1, done.
REQ-022 cmd_len=3, rlast asserted on beat 2 and rresp=2'b10 on beat 3 -> four beats forwarded, err=1 after beat 2, err held after done, cleared on next command accept.
REQ-023 areset pulsed during beat 3 of cmd_len=7 -> all outputs 0 while high, cmd_ready=1 next cycle after release, fresh command completes normally.
REQ-024 cmd_len=255 -> 256 beats, out_last only on beat 256.
